// File: rtl/writeback_unit_pkg.sv
// Shared types and constants for the register-file write-back path.
package writeback_unit_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef enum logic [0:0] {
        IDLE,
        WAIT_MEM
    } wb_state_e;

    // Unlisted funct3 codes extract as a word but are not alignment-checked.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr);
        logic bad;
        bad = 1'b0;
        case (funct3)
            LH, LHU: bad = addr[0];
            LW:      bad = (addr != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/writeback_unit_if.sv
// Retire/memory-response inputs and register-file write outputs of the write-back unit.
interface writeback_unit_if;

    logic                                 wbValid;
    logic                                 inReady;
    logic [4:0]                           wbRd;
    logic                                 wbRegWrite;
    logic                                 wbMemToReg;
    logic                                 wbIsJump;
    logic [2:0]                           wbFunct3;
    logic [writeback_unit_pkg::XLEN-1:0]  aluResult;
    logic [writeback_unit_pkg::XLEN-1:0]  pcOld;
    logic                                 memRespValid;
    logic [writeback_unit_pkg::XLEN-1:0]  memRespData;
    logic                                 regWrite;
    logic [4:0]                           rdAddr;
    logic [writeback_unit_pkg::XLEN-1:0]  writeData;
    logic                                 stall;
    logic                                 misalign;
    logic                                 timeoutErr;

    modport master (
        output wbValid, wbRd, wbRegWrite, wbMemToReg, wbIsJump, wbFunct3, aluResult, pcOld,
        output memRespValid, memRespData,
        input  inReady, regWrite, rdAddr, writeData, stall, misalign, timeoutErr
    );

    modport slave (
        input  wbValid, wbRd, wbRegWrite, wbMemToReg, wbIsJump, wbFunct3, aluResult, pcOld,
        input  memRespValid, memRespData,
        output inReady, regWrite, rdAddr, writeData, stall, misalign, timeoutErr
    );

endinterface

// File: rtl/writeback_unit_load_extend.sv
// Selects the byte/half/word of an aligned memory word and sign- or zero-extends it.
module writeback_unit_load_extend
    import writeback_unit_pkg::*;
(
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      addr,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{addr, 3'b000} +: 8];
        half_sel = addr[1] ? word[31:16] : word[15:0];
        data     = word;
        case (funct3)
            LB:      data = {{(XLEN - 8){byte_sel[7]}}, byte_sel};
            LBU:     data = {{(XLEN - 8){1'b0}}, byte_sel};
            LH:      data = {{(XLEN - 16){half_sel[15]}}, half_sel};
            LHU:     data = {{(XLEN - 16){1'b0}}, half_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// Write-back stage: drives the register-file write port from ALU/jump results and load data.
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = $clog2(TIMEOUT)
) (
    input logic               clk,
    input logic               rst,
    writeback_unit_if.slave   wb
);

    wb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]      rd_q, rd_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [1:0]      addr_q, addr_d;
    logic            reg_write_q, reg_write_d;
    logic [4:0]      rd_addr_q, rd_addr_d;
    logic [XLEN-1:0] write_data_q, write_data_d;
    logic            misalign_q, misalign_d;
    logic            timeout_err_q, timeout_err_d;
    logic [XLEN-1:0] load_data;
    logic            accept;

    writeback_unit_load_extend u_load_extend (
        .word   (wb.memRespData),
        .addr   (addr_q),
        .funct3 (funct3_q),
        .data   (load_data)
    );

    assign accept = wb.wbValid && (state_q == IDLE);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rd_d          = rd_q;
        funct3_d      = funct3_q;
        addr_d        = addr_q;
        reg_write_d   = 1'b0;
        rd_addr_d     = rd_addr_q;
        write_data_d  = write_data_q;
        misalign_d    = 1'b0;
        timeout_err_d = timeout_err_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (wb.wbMemToReg) begin
                        if (is_misaligned(wb.wbFunct3, wb.aluResult[1:0])) begin
                            misalign_d = 1'b1;
                        end else begin
                            state_d  = WAIT_MEM;
                            cnt_d    = '0;
                            rd_d     = wb.wbRd;
                            funct3_d = wb.wbFunct3;
                            addr_d   = wb.aluResult[1:0];
                        end
                    end else begin
                        reg_write_d  = wb.wbRegWrite && (wb.wbRd != 5'd0);
                        rd_addr_d    = wb.wbRd;
                        write_data_d = wb.wbIsJump ? (wb.pcOld + XLEN'(4)) : wb.aluResult;
                    end
                end
            end
            WAIT_MEM: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A response arriving on the final wait cycle beats the timeout.
                if (wb.memRespValid) begin
                    reg_write_d  = (rd_q != 5'd0);
                    rd_addr_d    = rd_q;
                    write_data_d = load_data;
                    state_d      = IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            rd_q          <= '0;
            funct3_q      <= '0;
            addr_q        <= '0;
            reg_write_q   <= 1'b0;
            rd_addr_q     <= '0;
            write_data_q  <= '0;
            misalign_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rd_q          <= rd_d;
            funct3_q      <= funct3_d;
            addr_q        <= addr_d;
            reg_write_q   <= reg_write_d;
            rd_addr_q     <= rd_addr_d;
            write_data_q  <= write_data_d;
            misalign_q    <= misalign_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign wb.inReady    = (state_q == IDLE);
    assign wb.stall      = (state_q == WAIT_MEM);
    assign wb.regWrite   = reg_write_q;
    assign wb.rdAddr     = rd_addr_q;
    assign wb.writeData  = write_data_q;
    assign wb.misalign   = misalign_q;
    assign wb.timeoutErr = timeout_err_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit with hand-computed expectations.
module tb_writeback_unit;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    writeback_unit_if wb_if ();

    writeback_unit #(
        .TIMEOUT (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        wb_if.wbValid      = 1'b0;
        wb_if.wbRd         = 5'd0;
        wb_if.wbRegWrite   = 1'b0;
        wb_if.wbMemToReg   = 1'b0;
        wb_if.wbIsJump     = 1'b0;
        wb_if.wbFunct3     = 3'b000;
        wb_if.aluResult    = 32'h0;
        wb_if.pcOld        = 32'h0;
        wb_if.memRespValid = 1'b0;
        wb_if.memRespData  = 32'h0;
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic jump, input logic [31:0] alu,
                             input logic [31:0] pc);
        wb_if.wbValid    = 1'b1;
        wb_if.wbRd       = rd;
        wb_if.wbRegWrite = 1'b1;
        wb_if.wbMemToReg = 1'b0;
        wb_if.wbIsJump   = jump;
        wb_if.aluResult  = alu;
        wb_if.pcOld      = pc;
    endtask

    task automatic drive_load(input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] addr);
        wb_if.wbValid    = 1'b1;
        wb_if.wbRd       = rd;
        wb_if.wbRegWrite = 1'b1;
        wb_if.wbMemToReg = 1'b1;
        wb_if.wbIsJump   = 1'b0;
        wb_if.wbFunct3   = f3;
        wb_if.aluResult  = addr;
    endtask

    // Accept a load, answer it on the third wait cycle, check the resulting write.
    task automatic run_load(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] word,
                            input logic [31:0] exp);
        drive_load(rd, f3, addr);
        tick();
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            check_eq({tag, "_stall"}, 32'(wb_if.stall), 32'd1);
            if (i == 2) begin
                wb_if.memRespValid = 1'b1;
                wb_if.memRespData  = word;
            end
            tick();
        end
        wb_if.memRespValid = 1'b0;
        check_eq({tag, "_we"}, 32'(wb_if.regWrite), 32'(rd != 5'd0));
        check_eq({tag, "_data"}, wb_if.writeData, exp);
        check_eq({tag, "_stall_off"}, 32'(wb_if.stall), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clear_inputs();
        rst = 1'b0;
        tick();
        tick();
        check_eq("rst_we", 32'(wb_if.regWrite), 32'd0);
        check_eq("rst_rd", 32'(wb_if.rdAddr), 32'd0);
        check_eq("rst_data", wb_if.writeData, 32'h0);
        check_eq("rst_mis", 32'(wb_if.misalign), 32'd0);
        check_eq("rst_tmo", 32'(wb_if.timeoutErr), 32'd0);
        check_eq("rst_ready", 32'(wb_if.inReady), 32'd1);
        check_eq("rst_stall", 32'(wb_if.stall), 32'd0);
        rst = 1'b1;
        tick();

        // ALU op, single pulse.
        drive_alu(5'd5, 1'b0, 32'h0000_1234, 32'h0000_0200);
        tick();
        clear_inputs();
        check_eq("alu_we", 32'(wb_if.regWrite), 32'd1);
        check_eq("alu_rd", 32'(wb_if.rdAddr), 32'd5);
        check_eq("alu_data", wb_if.writeData, 32'h0000_1234);
        tick();
        check_eq("alu_we_off", 32'(wb_if.regWrite), 32'd0);

        // jal writes pcOld+4.
        drive_alu(5'd1, 1'b1, 32'hDEAD_BEEF, 32'h0000_0100);
        tick();
        clear_inputs();
        check_eq("jal_we", 32'(wb_if.regWrite), 32'd1);
        check_eq("jal_data", wb_if.writeData, 32'h0000_0104);
        tick();
        check_eq("jal_we_off", 32'(wb_if.regWrite), 32'd0);

        // Back-to-back ALU ops, then a wrapping jump target.
        drive_alu(5'd2, 1'b0, 32'h0000_000A, 32'h0);
        tick();
        check_eq("b2b0_data", wb_if.writeData, 32'h0000_000A);
        drive_alu(5'd3, 1'b1, 32'h0, 32'hFFFF_FFFE);
        tick();
        check_eq("b2b1_we", 32'(wb_if.regWrite), 32'd1);
        check_eq("b2b1_rd", 32'(wb_if.rdAddr), 32'd3);
        check_eq("b2b1_data", wb_if.writeData, 32'h0000_0002);
        // Load accepted in the same cycle as the previous write pulse.
        run_load("lb", 5'd7, 3'b000, 32'h0000_1003, 32'h80FF_FF7F, 32'hFFFF_FF80);
        run_load("lbu", 5'd8, 3'b100, 32'h0000_1003, 32'h80FF_FF7F, 32'h0000_0080);
        run_load("lb0", 5'd8, 3'b000, 32'h0000_1000, 32'h80FF_FF7F, 32'h0000_007F);
        run_load("lh", 5'd9, 3'b001, 32'h0000_1002, 32'h80FF_FF7F, 32'hFFFF_80FF);
        run_load("lhu", 5'd9, 3'b101, 32'h0000_1000, 32'h80FF_FF7F, 32'h0000_FF7F);
        run_load("lw", 5'd10, 3'b010, 32'h0000_1004, 32'h80FF_FF7F, 32'h80FF_FF7F);
        check_eq("lw_rd", 32'(wb_if.rdAddr), 32'd10);
        tick();

        // ALU write to x0 is suppressed.
        drive_alu(5'd0, 1'b0, 32'h0000_5555, 32'h0);
        tick();
        clear_inputs();
        check_eq("x0_we", 32'(wb_if.regWrite), 32'd0);

        // Load to x0 still waits; wbValid during the wait is refused.
        drive_load(5'd0, 3'b000, 32'h0000_2000);
        tick();
        clear_inputs();
        drive_alu(5'd4, 1'b0, 32'h0000_0044, 32'h0);
        check_eq("busy_ready", 32'(wb_if.inReady), 32'd0);
        tick();
        clear_inputs();
        check_eq("busy_we", 32'(wb_if.regWrite), 32'd0);
        check_eq("busy_stall", 32'(wb_if.stall), 32'd1);
        wb_if.memRespValid = 1'b1;
        wb_if.memRespData  = 32'h1111_1111;
        tick();
        clear_inputs();
        check_eq("ldx0_we", 32'(wb_if.regWrite), 32'd0);
        check_eq("ldx0_stall", 32'(wb_if.stall), 32'd0);

        // Misaligned lh and lw are dropped.
        drive_load(5'd6, 3'b001, 32'h0000_1001);
        tick();
        clear_inputs();
        check_eq("mis_lh", 32'(wb_if.misalign), 32'd1);
        check_eq("mis_lh_we", 32'(wb_if.regWrite), 32'd0);
        check_eq("mis_lh_stall", 32'(wb_if.stall), 32'd0);
        drive_load(5'd6, 3'b010, 32'h0000_1002);
        tick();
        clear_inputs();
        check_eq("mis_lw", 32'(wb_if.misalign), 32'd1);
        check_eq("mis_lw_ready", 32'(wb_if.inReady), 32'd1);
        tick();
        check_eq("mis_off", 32'(wb_if.misalign), 32'd0);
        check_eq("mis_off_stall", 32'(wb_if.stall), 32'd0);

        // Response on the last wait cycle wins over the timeout.
        drive_load(5'd11, 3'b010, 32'h0000_3004);
        tick();
        clear_inputs();
        for (int i = 0; i < 15; i++) tick();
        check_eq("late_stall", 32'(wb_if.stall), 32'd1);
        wb_if.memRespValid = 1'b1;
        wb_if.memRespData  = 32'h1234_5678;
        tick();
        clear_inputs();
        check_eq("late_we", 32'(wb_if.regWrite), 32'd1);
        check_eq("late_data", wb_if.writeData, 32'h1234_5678);
        check_eq("late_tmo", 32'(wb_if.timeoutErr), 32'd0);

        // No response: timeout after 16 wait cycles, sticky.
        drive_load(5'd12, 3'b010, 32'h0000_3008);
        tick();
        clear_inputs();
        for (int i = 0; i < 15; i++) tick();
        check_eq("tmo_early", 32'(wb_if.timeoutErr), 32'd0);
        check_eq("tmo_stall", 32'(wb_if.stall), 32'd1);
        tick();
        check_eq("tmo_set", 32'(wb_if.timeoutErr), 32'd1);
        check_eq("tmo_ready", 32'(wb_if.inReady), 32'd1);
        check_eq("tmo_we", 32'(wb_if.regWrite), 32'd0);
        tick();
        check_eq("tmo_sticky", 32'(wb_if.timeoutErr), 32'd1);

        // Reset mid-wait, then a stale response.
        drive_load(5'd13, 3'b010, 32'h0000_4000);
        tick();
        clear_inputs();
        tick();
        rst = 1'b0;
        #2;
        check_eq("arst_stall", 32'(wb_if.stall), 32'd0);
        check_eq("arst_tmo", 32'(wb_if.timeoutErr), 32'd0);
        check_eq("arst_data", wb_if.writeData, 32'h0);
        tick();
        rst = 1'b1;
        wb_if.memRespValid = 1'b1;
        wb_if.memRespData  = 32'hCAFE_F00D;
        tick();
        clear_inputs();
        check_eq("stale_we", 32'(wb_if.regWrite), 32'd0);
        check_eq("stale_rd", 32'(wb_if.rdAddr), 32'd0);
        check_eq("stale_data", wb_if.writeData, 32'h0);
        check_eq("stale_ready", 32'(wb_if.inReady), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
